// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone
  } state_e;

  // Config register addresses
  localparam logic [1:0] CFG_LCR = 2'd0;
  localparam logic [1:0] CFG_DLL = 2'd1;
  localparam logic [1:0] CFG_DLH = 2'd2;

  // Divisor-latch access bit inside LCR
  localparam int unsigned LCR_DLAB = 7;

  // Register reset values
  localparam logic [7:0] LCR_RST = 8'h03;
  localparam logic [7:0] DLL_RST = 8'h02;
  localparam logic [7:0] DLH_RST = 8'h00;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of config, requester and UART-side signals for uart_tx_sched.
interface uart_tx_sched_if;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_err;
  logic [7:0] lcr;
  logic [7:0] dll;
  logic [7:0] dlh;
  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       req0_ready;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       ideal;
  logic       tx_err;

  // Environment side: requesters, config master and the UART itself
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, req0_valid, req1_valid, req0_data, req1_data, tx_busy,
    input  cfg_err, lcr, dll, dlh, req0_ready, req1_ready, tx_data, tx_start, ideal, tx_err
  );

  // Scheduler side
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, req0_valid, req1_valid, req0_data, req1_data, tx_busy,
    output cfg_err, lcr, dll, dlh, req0_ready, req1_ready, tx_data, tx_start, ideal, tx_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the one not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant; last_grant is the index of the previous winner
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules bytes from two requesters onto a UART transmitter and owns its config registers.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic            clk,
  input logic            rst_n,
  uart_tx_sched_if.slave bus
);

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        last_grant_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        tx_err_q;
  logic        cfg_err_q;
  logic [7:0]  lcr_q;
  logic [7:0]  dll_q;
  logic [7:0]  dlh_q;

  logic        in_idle;
  logic        grant_ok;
  logic        cfg_ok;
  logic [1:0]  grant;

  rr_arb2 u_arb (
    .req       ({bus.req1_valid, bus.req0_valid}),
    .last_grant(last_grant_q),
    .grant     (grant)
  );

  assign in_idle = (state_q == StIdle);
  // A config write in IDLE pre-empts any grant in the same cycle
  assign grant_ok = in_idle && !bus.cfg_we && !lcr_q[LCR_DLAB] && ({dlh_q, dll_q} != 16'h0000);

  assign bus.req0_ready = grant_ok && grant[0];
  assign bus.req1_ready = grant_ok && grant[1];
  assign bus.ideal      = in_idle;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_err     = tx_err_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.lcr        = lcr_q;
  assign bus.dll        = dll_q;
  assign bus.dlh        = dlh_q;

  // Decide whether the current config write may land
  always_comb begin
    cfg_ok = 1'b0;
    if (in_idle) begin
      unique case (bus.cfg_addr)
        CFG_LCR:          cfg_ok = 1'b1;
        CFG_DLL, CFG_DLH: cfg_ok = lcr_q[LCR_DLAB];
        default:          cfg_ok = 1'b0;
      endcase
    end
  end

  // Config registers and the rejected-write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcr_q     <= LCR_RST;
      dll_q     <= DLL_RST;
      dlh_q     <= DLH_RST;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && !cfg_ok;
      if (bus.cfg_we && cfg_ok) begin
        unique case (bus.cfg_addr)
          CFG_LCR: lcr_q <= bus.cfg_wdata;
          CFG_DLL: dll_q <= bus.cfg_wdata;
          CFG_DLH: dlh_q <= bus.cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  // Transfer FSM with registered start/error pulses and per-edge timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 16'h0000;
      last_grant_q <= 1'b1;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      tx_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_ok && (grant != 2'b00)) begin
            last_grant_q <= grant[1];
            tx_data_q    <= grant[1] ? bus.req1_data : bus.req0_data;
            tx_start_q   <= 1'b1;
            state_q      <= StStart;
          end
        end
        StStart: begin
          cnt_q   <= 16'h0000;
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (bus.tx_busy) begin
            cnt_q   <= 16'h0000;
            state_q <= StWaitDone;
          end else if (cnt_q == CntLast) begin
            tx_err_q <= 1'b1;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StWaitDone: begin
          if (!bus.tx_busy) begin
            state_q <= StIdle;
          end else if (cnt_q == CntLast) begin
            tx_err_q <= 1'b1;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the max cycles to wait on each tx_busy edge before abort.
REQ-002 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cfg_we  input  1  config write strobe, one cycle.
REQ-005 cfg_addr  input  2  config target: 0=LCR, 1=DLL, 2=DLH, 3=reserved.
REQ-006 cfg_wdata  input  8  config write data.
REQ-007 cfg_err  output  1  one-cycle pulse on a rejected config write.
REQ-008 lcr / dll / dlh  output  8 each  registered line-control and divisor values driven to the UART.
REQ-009 req0_valid, req1_valid  input  1  requester has a byte.
REQ-010 req0_data, req1_data  input  8  requester byte; SHALL be held stable while valid is high and ready is low.
REQ-011 req0_ready, req1_ready  output  1  byte accepted this cycle.
REQ-012 tx_data  output  8  byte presented to the UART transmitter.
REQ-013 tx_start  output  1  one-cycle start pulse (the UART intt input).
REQ-014 tx_busy  input  1  UART transmitter busy flag.
REQ-015 ideal  output  1  high only in IDLE; drives the UART idle input.
REQ-016 tx_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE: if any valid, lcr[7]==0, and {dlh,dll}!=0 -> grant one requester, assert its ready combinationally that cycle, register its data into tx_data, go START.
REQ-019 Arbitration SHALL be round-robin on last_grant: a single valid always wins; with both valid, the requester not last granted wins.
REQ-020 At most one ready SHALL be high in any cycle; ready SHALL never be high outside IDLE.
REQ-021 START: tx_start=1 for exactly one cycle, then WAIT_BUSY.
REQ-022 WAIT_BUSY: on tx_busy==1 go WAIT_DONE; WAIT_DONE: on tx_busy==0 go IDLE.
REQ-023 A 16-bit counter SHALL clear on entry to WAIT_BUSY and WAIT_DONE and increment each cycle there; at TIMEOUT_CYCLES-1 without the awaited edge, pulse tx_err and go IDLE.
REQ-024 Latency: valid+ready in cycle n -> tx_start in n+1; tx_data SHALL stay stable from n+1 until the return to IDLE.
REQ-025 Config writes SHALL be accepted only in IDLE, and in the cycle a grant occurs they SHALL take priority (no grant that cycle).
REQ-026 cfg_addr 1 or 2 SHALL be written only when lcr[7]==1 (DLAB); otherwise, or for addr 3, or outside IDLE, pulse cfg_err and leave registers unchanged.
REQ-027 LCR is always writable in IDLE; a write clearing lcr[7] SHALL enable grants from the next cycle.
REQ-028 With lcr[7]==1 or divisor zero, valids SHALL be held off (no ready), not dropped.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, lcr=8'h03, dll=8'h02, dlh=8'h00, tx_data=0, tx_start=0, tx_err=0, cfg_err=0, counter=0, last_grant=1 (req0 wins first tie).
REQ-030 Reset mid-transfer SHALL abandon the byte without tx_err; ideal=1 from reset release.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state enum, CFG_LCR/CFG_DLL/CFG_DLH address constants, the LCR_DLAB bit index (7), and the reset values of lcr/dll/dlh.
REQ-032 Arbitration SHALL be a sub-module rr_arb2 (two requests, last_grant in, one-hot grant out, combinational).

Verification
REQ-033 Reset, then req0_valid=1, data=8'hA5; UART model raises busy 2 cycles after start and holds it 10 -> req0_ready same cycle, tx_start next, tx_data=8'hA5, ideal=1 after busy drops.
REQ-034 Both valid continuously (8'h11, 8'h22) for 4 transfers -> grant order 0,1,0,1.
REQ-035 lcr=8'h83, write DLL=8'h10, DLH=8'h01, then lcr=8'h03 -> dll=8'h10, dlh=8'h01; no grant while DLAB=1.
REQ-036 With lcr[7]=0, write DLL=8'h55 -> cfg_err pulse, dll unchanged at 8'h02.
REQ-037 TIMEOUT_CYCLES=8, tx_busy stuck 0 -> tx_err 8 cycles after WAIT_BUSY entry, back to IDLE, next request serviced.
REQ-038 rst_n low during WAIT_DONE -> all outputs at reset values immediately, no tx_err.
